// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - UART 8N1 boot image receiver emitting 32-bit word writes
// Define UART_BOOT_LOADER_CKSUM_EN to require a trailing checksum word and expose cksum_err.
module uart_boot_loader #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [31:0] ADDR_BASE    = 32'h0000_0000,
  parameter int unsigned MAX_WORDS    = 16384
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [31:0] uart_data,
  output logic [31:0] uart_addr,
  output logic        uart_we,
  output logic        uart_done,
  output logic        frame_err,
  output logic        len_err,
`ifdef UART_BOOT_LOADER_CKSUM_EN
  output logic        cksum_err,
`endif
  output logic [15:0] words_loaded
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0]   MAX_N       = 32'(MAX_WORDS);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bstate_t;
`ifdef UART_BOOT_LOADER_CKSUM_EN
  typedef enum logic [2:0] {L_LEN, L_DATA, L_CKSUM, L_DONE, L_ERR} lstate_t;
  localparam lstate_t AFTER_DATA = L_CKSUM;
`else
  typedef enum logic [2:0] {L_LEN, L_DATA, L_DONE, L_ERR} lstate_t;
  localparam lstate_t AFTER_DATA = L_DONE;
`endif

  bstate_t bstate, bnext;
  lstate_t lstate, lnext;
  logic          rx_meta, rx_sync;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_shift;
  logic          stop_wait, byte_valid;
  logic          baud_tick, shift_en, byte_ok, stop_bad;
  logic [1:0]    byte_idx;
  logic [23:0]   word_buf;
  logic [31:0]   n_words, full_word;
  logic          accepting, word_done, take_len, load_word, last_word;
`ifdef UART_BOOT_LOADER_CKSUM_EN
  logic [31:0]   sum;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      bstate  <= B_IDLE;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      bstate  <= bnext;
    end
  end

  // After a bad stop bit, stay in B_STOP until the line returns high so a break is not read as a start
  always_comb begin
    bnext = bstate;
    case (bstate)
      B_IDLE:  if (!rx_sync) bnext = B_START;
      B_START: if (baud_tick) bnext = rx_sync ? B_IDLE : B_DATA;
      B_DATA:  if (baud_tick && bit_idx == 3'd7) bnext = B_STOP;
      B_STOP:  if (stop_wait ? rx_sync : (baud_tick && rx_sync)) bnext = B_IDLE;
      default: bnext = B_IDLE;
    endcase
  end

  always_comb begin
    baud_tick = (baud_cnt == '0);
    shift_en  = (bstate == B_DATA) && baud_tick;
    byte_ok   = (bstate == B_STOP) && !stop_wait && baud_tick && rx_sync;
    stop_bad  = (bstate == B_STOP) && !stop_wait && baud_tick && !rx_sync;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      baud_cnt   <= '0;
      bit_idx    <= '0;
      rx_shift   <= '0;
      stop_wait  <= 1'b0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= byte_ok;
      if (bnext != bstate) baud_cnt <= (bnext == B_START) ? HALF_RELOAD : FULL_RELOAD;
      else if (baud_tick)  baud_cnt <= FULL_RELOAD;
      else                 baud_cnt <= baud_cnt - CW'(1);
      if (bstate != B_DATA) bit_idx <= '0;
      else if (shift_en)    bit_idx <= bit_idx + 3'd1;
      if (shift_en) rx_shift <= {rx_sync, rx_shift[7:1]};
      if (stop_bad) begin
        stop_wait <= 1'b1;
        frame_err <= 1'b1;
      end else if (bstate != B_STOP) begin
        stop_wait <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) lstate <= L_LEN;
    else        lstate <= lnext;
  end

  always_comb begin
    lnext = lstate;
    case (lstate)
      L_LEN: if (word_done) begin
        if (full_word == '0)       lnext = L_DONE;
        else if (full_word > MAX_N) lnext = L_ERR;
        else                       lnext = L_DATA;
      end
      L_DATA: if (uart_we && last_word) lnext = AFTER_DATA;
`ifdef UART_BOOT_LOADER_CKSUM_EN
      L_CKSUM: if (word_done) lnext = (full_word == sum) ? L_DONE : L_ERR;
`endif
      default: lnext = lstate;
    endcase
  end

  always_comb begin
`ifdef UART_BOOT_LOADER_CKSUM_EN
    accepting = (lstate == L_LEN) || (lstate == L_DATA) || (lstate == L_CKSUM);
`else
    accepting = (lstate == L_LEN) || (lstate == L_DATA);
`endif
    word_done = byte_valid && accepting && (byte_idx == 2'd3);
    full_word = {rx_shift, word_buf};
    take_len  = word_done && (lstate == L_LEN);
    load_word = word_done && (lstate == L_DATA);
    last_word = (({16'd0, words_loaded}) + 32'd1) == n_words;
    uart_done = (lstate == L_DONE);
  end

  // Address and count advance the cycle after each strobe, so the strobe carries this word's address
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_idx     <= '0;
      word_buf     <= '0;
      n_words      <= '0;
      uart_we      <= 1'b0;
      uart_data    <= '0;
      uart_addr    <= ADDR_BASE;
      words_loaded <= '0;
      len_err      <= 1'b0;
    end else begin
      if (byte_valid && accepting) begin
        case (byte_idx)
          2'd0:    word_buf[7:0]   <= rx_shift;
          2'd1:    word_buf[15:8]  <= rx_shift;
          2'd2:    word_buf[23:16] <= rx_shift;
          default: ;
        endcase
        byte_idx <= byte_idx + 2'd1;
      end
      uart_we <= load_word;
      if (load_word) uart_data <= full_word;
      if (uart_we) begin
        uart_addr    <= uart_addr + 32'd4;
        words_loaded <= words_loaded + 16'd1;
      end
      if (take_len) begin
        n_words <= full_word;
        if (full_word > MAX_N) len_err <= 1'b1;
      end
    end
  end

`ifdef UART_BOOT_LOADER_CKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum       <= '0;
      cksum_err <= 1'b0;
    end else begin
      if (take_len)       sum <= full_word;
      else if (load_word) sum <= sum + full_word;
      if (word_done && lstate == L_CKSUM && full_word != sum) cksum_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb/tb_uart_boot_loader.sv - scoreboard bench for uart_boot_loader
// Checksum scenario runs only when UART_BOOT_LOADER_CKSUM_EN is defined.
module tb_uart_boot_loader;
  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [31:0] uart_data, uart_addr;
  logic        uart_we, uart_done, frame_err, len_err;
  logic [15:0] words_loaded;
`ifdef UART_BOOT_LOADER_CKSUM_EN
  logic        cksum_err;
`endif

  uart_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_BASE(32'h0000_0000), .MAX_WORDS(16384)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .uart_data(uart_data), .uart_addr(uart_addr), .uart_we(uart_we),
    .uart_done(uart_done), .frame_err(frame_err), .len_err(len_err),
`ifdef UART_BOOT_LOADER_CKSUM_EN
    .cksum_err(cksum_err),
`endif
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] addr; logic [31:0] data;} wr_t;
  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && uart_we) begin
      if (exp_q.size() == 0) begin
        check("we_unexpected", 32'(uart_we), 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("we_addr", uart_addr, e.addr);
        check("we_data", uart_data, e.data);
      end
    end
  end

  task automatic do_reset();
    rx = 1'b1;
    rst_n = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 200 && !uart_done; i++) @(negedge clk);
    check(tag, 32'(uart_done), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_data"}, uart_data, 32'd0);
    check({tag, "_addr"}, uart_addr, 32'd0);
    check({tag, "_we"}, 32'(uart_we), 32'd0);
    check({tag, "_done"}, 32'(uart_done), 32'd0);
    check({tag, "_ferr"}, 32'(frame_err), 32'd0);
    check({tag, "_lerr"}, 32'(len_err), 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    // 1: two-word image
    do_reset();
    check_idle("t1_reset");
    exp_q.push_back('{addr: 32'h0, data: 32'h0000_0013});
    exp_q.push_back('{addr: 32'h4, data: 32'hDEAD_BEEF});
    send_word(32'd2);
    send_word(32'h0000_0013);
    send_word(32'hDEAD_BEEF);
    wait_done("t1_done");
    check("t1_words", 32'(words_loaded), 32'd2);
    check("t1_ferr", 32'(frame_err), 32'd0);
    check("t1_addr_end", uart_addr, 32'h8);
    check("t1_q_empty", 32'(exp_q.size()), 32'd0);
    send_word(32'h1234_5678);
    check("t1_done_ignores_rx", 32'(words_loaded), 32'd2);

    // 2: empty image
    do_reset();
    send_word(32'd0);
    wait_done("t2_done");
    check("t2_addr", uart_addr, 32'h0);
    check("t2_words", 32'(words_loaded), 32'd0);

    // 3: framing error does not consume a byte slot
    do_reset();
    exp_q.push_back('{addr: 32'h0, data: 32'h4433_2211});
    send_word(32'd1);
    send_byte(8'h55, 1'b0);
    check("t3_ferr_set", 32'(frame_err), 32'd1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    wait_done("t3_done");
    check("t3_ferr_sticky", 32'(frame_err), 32'd1);
    check("t3_q_empty", 32'(exp_q.size()), 32'd0);

    // 4: oversize header
    do_reset();
    send_word(32'h0000_FFFF);
    repeat (10) @(negedge clk);
    check("t4_lerr", 32'(len_err), 32'd1);
    send_word(32'hAAAA_5555);
    send_word(32'h0000_0001);
    check("t4_done", 32'(uart_done), 32'd0);
    check("t4_words", 32'(words_loaded), 32'd0);

    // 5: short glitch while idle
    do_reset();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("t5_ferr", 32'(frame_err), 32'd0);
    check("t5_lerr", 32'(len_err), 32'd0);
    exp_q.push_back('{addr: 32'h0, data: 32'hCAFE_F00D});
    send_word(32'd1);
    send_word(32'hCAFE_F00D);
    wait_done("t5_done");
    check("t5_q_empty", 32'(exp_q.size()), 32'd0);

    // 6: reset in the middle of an image
    do_reset();
    exp_q.push_back('{addr: 32'h0, data: 32'h0102_0304});
    send_word(32'd2);
    send_word(32'h0102_0304);
    send_byte(8'hA5, 1'b1);
    check("t6_partial_q", 32'(exp_q.size()), 32'd0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("t6_in_reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.push_back('{addr: 32'h0, data: 32'h0102_0304});
    exp_q.push_back('{addr: 32'h4, data: 32'hF0E0_D0C0});
    send_word(32'd2);
    send_word(32'h0102_0304);
    send_word(32'hF0E0_D0C0);
    wait_done("t6_done");
    check("t6_words", 32'(words_loaded), 32'd2);
    check("t6_q_empty", 32'(exp_q.size()), 32'd0);

`ifdef UART_BOOT_LOADER_CKSUM_EN
    // 7: checksum word
    do_reset();
    exp_q.push_back('{addr: 32'h0, data: 32'd5});
    send_word(32'd1);
    send_word(32'd5);
    send_word(32'd6);
    wait_done("t7_done_ok");
    check("t7_cerr_ok", 32'(cksum_err), 32'd0);
    do_reset();
    exp_q.push_back('{addr: 32'h0, data: 32'd5});
    send_word(32'd1);
    send_word(32'd5);
    send_word(32'd7);
    repeat (10) @(negedge clk);
    check("t7_cerr_bad", 32'(cksum_err), 32'd1);
    check("t7_done_bad", 32'(uart_done), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
